// File: rtl/csr_row_dot_round.sv
// csr_row_dot_round: one output element of a CSR-sparse x dense-column product.
// The selected row of X is fetched, its nonzeros are paired with the matching
// Y entries, and the signed fixed-point dot product is optionally rounded and
// saturated. The whole datapath is combinational and feeds one result register.
//
// Handshake: an input transfer happens on a rising edge with in_valid && in_ready;
// an output transfer happens with out_valid && out_ready. in_ready is
// !out_valid || out_ready, so a held result blocks new inputs and a drained
// result can be replaced in the same cycle (one result per clock).
module csr_row_dot_round #(
    parameter int N               = 2,
    parameter int M               = 2,
    parameter int NZN             = 4,
    parameter int NZN_ROW         = 2,
    parameter int X_WIDTH         = 8,
    parameter int X_FRAC_WIDTH    = 1,
    parameter int Y_WIDTH         = 8,
    parameter int Y_FRAC_WIDTH    = 1,
    parameter int ADDR_WIDTH      = 16,
    parameter int OUTPUT_ROUNDING = 1,
    parameter int OUT_WIDTH       = 16,
    parameter int OUT_FRAC_WIDTH  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NZN-1:0][X_WIDTH-1:0]       x_data,
    input  logic [NZN-1:0][ADDR_WIDTH-1:0]    x_col_index,
    input  logic [N:0][ADDR_WIDTH-1:0]        x_row_bound,
    input  logic [ADDR_WIDTH-1:0]             row_sel,
    input  logic [M-1:0][Y_WIDTH-1:0]         y_col,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int ACC_WIDTH      = X_WIDTH + Y_WIDTH + $clog2(M);
    localparam int ACC_FRAC_WIDTH = X_FRAC_WIDTH + Y_FRAC_WIDTH;
    localparam int PROD_WIDTH     = X_WIDTH + Y_WIDTH;
    localparam int IDX_W          = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]        row_start;
    logic [ADDR_WIDTH-1:0]        row_end;
    logic [ADDR_WIDTH-1:0]        row_count;
    logic signed [X_WIDTH-1:0]    lane_x   [NZN_ROW];
    logic [ADDR_WIDTH-1:0]        lane_idx [NZN_ROW];
    logic signed [Y_WIDTH-1:0]    lane_y   [NZN_ROW];
    logic signed [PROD_WIDTH-1:0] lane_prod[NZN_ROW];
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]         result;

    logic                         out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;

    // Row fetch: rows outside 0..N-1 leave start == end, giving an empty row.
    always_comb begin
        row_start = '0;
        row_end   = '0;
        for (int r = 0; r < N; r++) begin
            if (row_sel == ADDR_WIDTH'(r)) begin
                row_start = x_row_bound[r];
                row_end   = x_row_bound[r+1];
            end
        end
        row_count = '0;
        if (row_end > row_start) begin
            if ((row_end - row_start) > ADDR_WIDTH'(NZN_ROW))
                row_count = ADDR_WIDTH'(NZN_ROW);
            else
                row_count = row_end - row_start;
        end
    end

    // Lane select: lane s takes nonzero start+s when inside the row and the
    // arrays; the position is widened by one bit so start+s cannot wrap.
    always_comb begin
        for (int s = 0; s < NZN_ROW; s++) begin
            lane_x[s]   = '0;
            lane_idx[s] = '0;
            if (ADDR_WIDTH'(s) < row_count) begin
                for (int k = 0; k < NZN; k++) begin
                    if (({1'b0, row_start} + IDX_W'(s)) == IDX_W'(k)) begin
                        lane_x[s]   = x_data[k];
                        lane_idx[s] = x_col_index[k];
                    end
                end
            end
        end
    end

    // Gather: a column index beyond the Y column reads as zero.
    always_comb begin
        for (int s = 0; s < NZN_ROW; s++) begin
            lane_y[s] = '0;
            for (int j = 0; j < M; j++) begin
                if (lane_idx[s] == ADDR_WIDTH'(j))
                    lane_y[s] = y_col[j];
            end
        end
    end

    // Dot product: full-precision signed products summed in the accumulator format.
    always_comb begin
        acc = '0;
        for (int s = 0; s < NZN_ROW; s++) begin
            lane_prod[s] = PROD_WIDTH'(lane_x[s]) * PROD_WIDTH'(lane_y[s]);
            acc          = acc + ACC_WIDTH'(lane_prod[s]);
        end
    end

    if (OUTPUT_ROUNDING != 0) begin : g_round
        localparam int DROP = (ACC_FRAC_WIDTH > OUT_FRAC_WIDTH) ? (ACC_FRAC_WIDTH - OUT_FRAC_WIDTH) : 0;
        localparam int SHL  = (OUT_FRAC_WIDTH > ACC_FRAC_WIDTH) ? (OUT_FRAC_WIDTH - ACC_FRAC_WIDTH) : 0;
        // Wide enough that neither the rounding add nor the left shift can overflow.
        localparam int WW   = ACC_WIDTH + SHL + OUT_WIDTH + 2;
        localparam logic signed [WW-1:0] OUT_MAX = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [WW-1:0] OUT_MIN = {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

        logic signed [WW-1:0] acc_wide;
        logic signed [WW-1:0] scaled;

        assign acc_wide = WW'(acc);

        if (DROP > 0) begin : g_drop
            localparam logic signed [WW-1:0] HALF = WW'(1) << (DROP - 1);
            // Round half up: add half an output LSB, then floor via arithmetic shift.
            assign scaled = (acc_wide + HALF) >>> DROP;
        end else begin : g_shl
            assign scaled = acc_wide <<< SHL;
        end

        // Saturate to the signed output range.
        always_comb begin
            if (scaled > OUT_MAX)
                result = OUT_MAX[OUT_WIDTH-1:0];
            else if (scaled < OUT_MIN)
                result = OUT_MIN[OUT_WIDTH-1:0];
            else
                result = scaled[OUT_WIDTH-1:0];
        end
    end else begin : g_pass
        if (OUT_WIDTH != ACC_WIDTH || OUT_FRAC_WIDTH != ACC_FRAC_WIDTH) begin : g_bad_fmt
            $fatal(1, "csr_row_dot_round: pass-through output must match the accumulator format");
        end
        assign result = OUT_WIDTH'(acc);
    end

    // Output register next state: load on input transfer, clear after a drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result register; reset discards any pending result immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_csr_row_dot_round.sv
// Bench for csr_row_dot_round: a default instance and an 8-bit saturating
// instance share one input stream and are scored against a plain-arithmetic
// model of the row dot product.
module tb_csr_row_dot_round;

    localparam int N       = 2;
    localparam int M       = 2;
    localparam int NZN     = 4;
    localparam int NZN_ROW = 2;
    localparam int AW      = 16;
    localparam int ACC_FRAC = 2;

    logic                     clk;
    logic                     rst;
    logic [NZN-1:0][7:0]      x_data;
    logic [NZN-1:0][AW-1:0]   x_col_index;
    logic [N:0][AW-1:0]       x_row_bound;
    logic [AW-1:0]            row_sel;
    logic [M-1:0][7:0]        y_col;
    logic                     in_valid;
    logic                     out_ready;

    logic                     in_ready, in_ready_s;
    logic [15:0]              out_data;
    logic [7:0]               out_data_s;
    logic                     out_valid, out_valid_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_ready = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp_sat_q[$];

    csr_row_dot_round dut (
        .clk(clk), .rst(rst), .x_data(x_data), .x_col_index(x_col_index),
        .x_row_bound(x_row_bound), .row_sel(row_sel), .y_col(y_col),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    csr_row_dot_round #(.OUT_WIDTH(8), .OUT_FRAC_WIDTH(0)) dut_sat (
        .clk(clk), .rst(rst), .x_data(x_data), .x_col_index(x_col_index),
        .x_row_bound(x_row_bound), .row_sel(row_sel), .y_col(y_col),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint ref_dot(input int xd[NZN], input int xc[NZN], input int xb[N+1],
                                       input int rs, input int yc[M], input int ow, input int ofrac);
        longint acc = 0;
        longint r, den, hi, lo;
        int st, en, cnt, p, d;
        if (rs < N) begin
            st  = xb[rs];
            en  = xb[rs+1];
            cnt = (en > st) ? ((en - st < NZN_ROW) ? en - st : NZN_ROW) : 0;
            for (int s = 0; s < cnt; s++) begin
                p = st + s;
                if (p < NZN) begin
                    if (xc[p] < M)
                        acc += longint'(xd[p]) * longint'(yc[xc[p]]);
                end
            end
        end
        d = ACC_FRAC - ofrac;
        if (d > 0) begin
            den = longint'(1) << d;
            r = acc + den / 2;
            // floor division toward minus infinity
            if (r < 0 && (r % den) != 0) r = r / den - 1;
            else r = r / den;
        end else begin
            r = acc * (longint'(1) << (-d));
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input int xd[NZN], input int xc[NZN], input int xb[N+1], input int rs, input int yc[M]);
        for (int i = 0; i < NZN; i++) begin
            x_data[i]      = 8'(xd[i]);
            x_col_index[i] = AW'(xc[i]);
        end
        for (int i = 0; i <= N; i++) x_row_bound[i] = AW'(xb[i]);
        for (int i = 0; i < M; i++) y_col[i] = 8'(yc[i]);
        row_sel = AW'(rs);
    endtask

    // Offer one transaction, wait for acceptance, return the stall count.
    task automatic send(input int xd[NZN], input int xc[NZN], input int xb[N+1], input int rs,
                        input int yc[M], output int waits);
        waits = 0;
        apply(xd, xc, xb, rs, yc);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_val("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(16'(ref_dot(xd, xc, xb, rs, yc, 16, 0)));
            exp_sat_q.push_back(8'(ref_dot(xd, xc, xb, rs, yc, 8, 0)));
            @(posedge clk);
            #1;
            check_val("lat_valid", out_valid, 1);
            check_val("lat_valid_sat", out_valid_s, 1);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_val("drain_left", exp_q.size(), 0);
    endtask

    // Randomised downstream readiness, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [15:0] e;
        logic [7:0]  es;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    es = exp_sat_q.pop_front();
                    check_val("out_data", $signed(out_data), $signed(e));
                    check_val("out_data_sat", $signed(out_data_s), $signed(es));
                    check_val("out_valid_sat", out_valid_s, 1);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int xd[NZN];
        int xc[NZN];
        int xb[N+1];
        int yc[M];
        int w;

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        xd = '{4, 6, -2, 3};
        xc = '{0, 1, 1, 0};
        xb = '{0, 2, 4};
        yc = '{2, 4};
        apply(xd, xc, xb, 0, yc);

        // reset state
        #3;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid_after", out_valid, 0);

        // row 0 then row 1 (rounding of -0.5 to 0), back to back
        send(xd, xc, xb, 0, yc, w);
        check_val("row0_direct", $signed(out_data), 8);
        send(xd, xc, xb, 1, yc, w);
        check_val("row1_direct", $signed(out_data), 0);
        idle(2);

        // empty row and out-of-range row
        xb = '{0, 0, 2};
        send(xd, xc, xb, 0, yc, w);
        check_val("empty_row", $signed(out_data), 0);
        send(xd, xc, xb, 2, yc, w);
        check_val("row_sel_ge_n", $signed(out_data), 0);
        idle(2);

        // saturation on the 8-bit instance
        xd = '{127, 127, 0, 0};
        xc = '{0, 1, 0, 0};
        xb = '{0, 2, 4};
        yc = '{127, 127};
        send(xd, xc, xb, 0, yc, w);
        check_val("sat_pos", $signed(out_data_s), 127);
        check_val("sat_wide", $signed(out_data), 8065);
        xd = '{-128, -128, 0, 0};
        yc = '{127, 127};
        send(xd, xc, xb, 0, yc, w);
        check_val("sat_neg", $signed(out_data_s), -128);
        idle(2);

        // backpressure: held result blocks input and stays stable
        xd = '{4, 6, -2, 3};
        xc = '{0, 1, 1, 0};
        yc = '{2, 4};
        out_ready = 1'b0;
        send(xd, xc, xb, 0, yc, w);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_out_data", $signed(out_data), 8);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(xd, xc, xb, i % 3, yc, w);
            check_val("b2b_stall", w, 0);
        end
        idle(2);

        // randomised traffic
        rnd_ready = 1;
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < NZN; i++) begin
                xd[i] = int'($urandom_range(0, 255)) - 128;
                xc[i] = int'($urandom_range(0, 2));
            end
            for (int i = 0; i <= N; i++) xb[i] = int'($urandom_range(0, 6));
            for (int i = 0; i < M; i++) yc[i] = int'($urandom_range(0, 255)) - 128;
            send(xd, xc, xb, int'($urandom_range(0, 3)), yc, w);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        in_valid = 1'b0;
        rnd_ready = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // asynchronous reset while a result is held
        out_ready = 1'b0;
        xd = '{4, 6, -2, 3};
        xc = '{0, 1, 1, 0};
        xb = '{0, 2, 4};
        yc = '{2, 4};
        send(xd, xc, xb, 0, yc, w);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_out_data", out_data, 0);
        check_val("arst_out_data_sat", out_data_s, 0);
        check_val("arst_in_ready", in_ready, 1);
        exp_q.delete();
        exp_sat_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;

        // recovery after reset
        send(xd, xc, xb, 1, yc, w);
        idle(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
